rr_mux_arb: RTL and testbench
=============================

Name: rr_mux_arb

Overview:
- Parametrised successor to the fixed 7-way 8-bit select mux.
- An N-channel, W-bit multiplexer with per-channel valid/ready handshakes.
- Two selection modes: round-robin arbitration, or a fixed-select override.
- Registered output stage with backpressure. Sits between multiple producers (sprite/pixel/data sources) and one shared consumer.

Parameters:
- WIDTH, 8, data width per channel in bits.
- NUM_CH, 7, number of input channels (2..16).
- SEL_W, $clog2(NUM_CH), width of select and channel-ID fields (derived; do not override).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Din  input  NUM_CH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- Din_valid  input  NUM_CH  per-channel data-valid.
- Din_ready  output  NUM_CH  per-channel accept, at most one bit high.
- mode  input  1  0 = round-robin, 1 = fixed select.
- select  input  SEL_W  channel index used when mode=1.
- Dout  output  WIDTH  registered output data.
- Dout_ch  output  SEL_W  index of the channel that supplied Dout.
- Dout_valid  output  1  Dout/Dout_ch hold a valid beat.
- Dout_ready  input  1  consumer accept.

Behaviour:
- Reset (async, on Reset=1): Dout=0, Dout_ch=0, Dout_valid=0, rr_ptr=0. Din_ready is all-zero while Reset=1.
- Output stage has two states:
  - EMPTY: Dout_valid=0.
  - FULL: Dout_valid=1.
- load_en = !Dout_valid || Dout_ready. The output register loads only when load_en=1.
- Grant is combinational from current inputs:
  - mode=0: first channel i with Din_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_CH (wraps NUM_CH-1 -> 0).
  - mode=1: grant = select if select < NUM_CH and Din_valid[select]=1; otherwise no grant.
  - Out-of-range select never aliases to a channel (no default-to-last behaviour).
- Din_ready[i] = load_en && grant_valid && (grant==i). Din_ready is independent of Dout_valid when Dout_ready=1, so full throughput is 1 beat/cycle.
- Transfer on channel g (Din_valid[g] && Din_ready[g]), next edge:
  - Dout <= Din[g], Dout_ch <= g, Dout_valid <= 1.
  - If mode=0: rr_ptr <= (g==NUM_CH-1) ? 0 : g+1.
  - If mode=1: rr_ptr unchanged.
- load_en=1 with no grant: Dout_valid <= 0 (FULL->EMPTY if Dout_ready=1). Dout and Dout_ch hold their old values.
- load_en=0 (FULL, Dout_ready=0): Dout, Dout_ch, Dout_valid and rr_ptr all hold. All Din_ready=0.
- Simultaneous output drain and input accept: the register reloads in the same cycle, with no bubble.
- Latency: 1 cycle from accepted input to Dout_valid.
- Mode/select changes:
  - Sampled combinationally each cycle.
  - A beat already in the output register is unaffected.
  - Switching mode 1->0 resumes round-robin from the retained rr_ptr.
- Producer rule: a producer holding Din_valid=1 without Din_ready may change Din. No stability requirement is placed on unaccepted data.
- Reset mid-operation: the held beat is discarded immediately (Dout_valid=0 asynchronously). rr_ptr returns to 0.

Test Plan:
- Reset then idle: Reset=1 mid-stream with Dout_valid=1 -> Dout_valid=0, Dout=0, Dout_ch=0 before the next edge; Din_ready=0 while Reset=1.
- Round-robin fairness: mode=0, all 7 channels valid with Din[i]=8'h10+i, Dout_ready=1 -> Dout_ch sequence 0,1,2,3,4,5,6,0,… on consecutive cycles; Dout=8'h10..8'h16; one beat per cycle.
- Sparse round-robin with wrap: valid only on channels 2 and 6, rr_ptr=3 -> grants 6, then 2, then 6; rr_ptr wraps 6->0 correctly.
- Backpressure: Dout_ready=0 for 3 cycles while FULL -> Dout and Dout_ch stable; all Din_ready=0. On Dout_ready=1, the next beat loads that same edge.
- Fixed select: mode=1, select=4, channels 0..6 valid -> only channel 4 granted; Dout_ch=4 every cycle. Then select=7 (out of range) -> no grant; Dout_valid falls to 0 after the drain.
- Mode switch: mode=1 (select=5) for 2 beats, then mode=0 with rr_ptr=1 -> the next grant is channel 1, not 6.

Source files
------------

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel, W-bit multiplexer with per-channel valid/ready
// handshakes. It has a registered output stage with backpressure.
//
// Selection is either round-robin (mode=0) or a fixed channel given by
// `select` (mode=1). An out-of-range `select` grants nothing.
//
// Handshake rule (all ports): a beat moves on a rising Clk edge exactly when
// valid and ready are both high in the cycle before that edge. A producer may
// change Din while its valid is high and ready is low. Din_ready has at most
// one bit high and is combinational from the current inputs and state.
//
// Ports:
//   Clk         system clock, rising edge
//   Reset       asynchronous, active-high reset
//   Din         flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   Din_valid   per-channel data valid
//   Din_ready   per-channel accept (one-hot or zero, zero while Reset=1)
//   mode        0 = round-robin, 1 = fixed select
//   select      channel index used when mode=1
//   Dout        registered output data
//   Dout_ch     index of the channel that supplied Dout
//   Dout_valid  Dout/Dout_ch hold a valid beat
//   Dout_ready  consumer accept
//   dbg_state   output stage state (0 = EMPTY, 1 = FULL)
//   dbg_rr_ptr  current round-robin start pointer
module rr_mux_arb #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 7,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_CH*WIDTH-1:0] Din,
  input  logic [NUM_CH-1:0]       Din_valid,
  output logic [NUM_CH-1:0]       Din_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        select,
  output logic [WIDTH-1:0]        Dout,
  output logic [SEL_W-1:0]        Dout_ch,
  output logic                    Dout_valid,
  input  logic                    Dout_ready,
  output logic                    dbg_state,
  output logic [SEL_W-1:0]        dbg_rr_ptr
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  out_state_e       state;
  out_state_e       state_nxt;
  logic [SEL_W-1:0] rr_ptr;

  logic             load_en;
  logic             accept;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic [WIDTH-1:0] grant_data;

  // Round-robin search split in two passes so that no wrapped index
  // arithmetic is needed: the lowest valid channel at or above rr_ptr wins.
  // If there is none, the lowest valid channel overall wins, which is the
  // wrap-around case.
  logic [SEL_W-1:0] hi_idx;
  logic             hi_found;
  logic [SEL_W-1:0] lo_idx;
  logic             lo_found;

  assign load_en    = (state == EMPTY) || Dout_ready;
  assign accept     = !Reset && load_en && grant_valid;
  assign Dout_valid = (state == FULL);
  assign dbg_state  = (state == FULL);
  assign dbg_rr_ptr = rr_ptr;

  always_comb begin
    hi_idx      = '0;
    hi_found    = 1'b0;
    lo_idx      = '0;
    lo_found    = 1'b0;
    grant       = '0;
    grant_valid = 1'b0;
    grant_data  = '0;

    // Descending scan: the last hit assigned is the lowest index.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (Din_valid[i]) begin
        lo_idx   = SEL_W'(i);
        lo_found = 1'b1;
        if (SEL_W'(i) >= rr_ptr) begin
          hi_idx   = SEL_W'(i);
          hi_found = 1'b1;
        end
      end
    end

    if (!mode) begin
      grant_valid = hi_found || lo_found;
      grant       = hi_found ? hi_idx : lo_idx;
    end else begin
      // Compare against every legal index. A select value >= NUM_CH then
      // matches nothing, so it never aliases to a real channel.
      for (int i = 0; i < NUM_CH; i++) begin
        if ((select == SEL_W'(i)) && Din_valid[i]) begin
          grant       = SEL_W'(i);
          grant_valid = 1'b1;
        end
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data = Din[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    Din_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      Din_ready[i] = accept && (grant == SEL_W'(i));
    end
  end

  // Output stage state machine.
  always_comb begin
    state_nxt = state;
    if (load_en) begin
      state_nxt = grant_valid ? FULL : EMPTY;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Data, channel ID and round-robin pointer. On a drain with no grant,
  // Dout/Dout_ch keep their old values and only the state drops to EMPTY.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Dout    <= '0;
      Dout_ch <= '0;
      rr_ptr  <= '0;
    end else if (accept) begin
      Dout    <= grant_data;
      Dout_ch <= grant;
      if (!mode) begin
        rr_ptr <= (grant == SEL_W'(NUM_CH - 1)) ? '0 : grant + SEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed testbench for rr_mux_arb (WIDTH=8, NUM_CH=7).
// Inputs change 1 ns after a rising edge. Registered outputs are checked
// after that edge. Combinational Din_ready is checked 1 ns after the inputs
// change.
module tb_rr_mux_arb;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 7;
  localparam int SEL_W  = $clog2(NUM_CH);

  logic                    Clk;
  logic                    Reset;
  logic [NUM_CH*WIDTH-1:0] Din;
  logic [NUM_CH-1:0]       Din_valid;
  logic [NUM_CH-1:0]       Din_ready;
  logic                    mode;
  logic [SEL_W-1:0]        select;
  logic [WIDTH-1:0]        Dout;
  logic [SEL_W-1:0]        Dout_ch;
  logic                    Dout_valid;
  logic                    Dout_ready;
  logic                    dbg_state;
  logic [SEL_W-1:0]        dbg_rr_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  rr_mux_arb #(
    .WIDTH (WIDTH),
    .NUM_CH(NUM_CH)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Din       (Din),
    .Din_valid (Din_valid),
    .Din_ready (Din_ready),
    .mode      (mode),
    .select    (select),
    .Dout      (Dout),
    .Dout_ch   (Dout_ch),
    .Dout_valid(Dout_valid),
    .Dout_ready(Dout_ready),
    .dbg_state (dbg_state),
    .dbg_rr_ptr(dbg_rr_ptr)
  );

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Checking
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver helpers
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_din(input logic [7:0] base);
    for (int i = 0; i < NUM_CH; i++) begin
      Din[i*WIDTH +: WIDTH] = base + 8'(i);
    end
  endtask

  task automatic check_beat(input string tag, input logic [7:0] exp_data,
                            input logic [SEL_W-1:0] exp_ch);
    check({tag, "_valid"}, 32'(Dout_valid), 32'd1);
    check({tag, "_data"},  32'(Dout),       32'(exp_data));
    check({tag, "_ch"},    32'(Dout_ch),    32'(exp_ch));
  endtask

  initial begin
    Reset      = 1'b1;
    Din        = '0;
    Din_valid  = '1;
    mode       = 1'b0;
    select     = '0;
    Dout_ready = 1'b1;
    load_din(8'h10);
    tick();
    tick();

    // Reset state: outputs cleared and Din_ready gated even with all valid.
    check("rst_dout_valid", 32'(Dout_valid), 32'd0);
    check("rst_dout",       32'(Dout),       32'd0);
    check("rst_dout_ch",    32'(Dout_ch),    32'd0);
    check("rst_din_ready",  32'(Din_ready),  32'd0);
    check("rst_rr_ptr",     32'(dbg_rr_ptr), 32'd0);

    Reset = 1'b0;
    #1;

    // Round-robin with all channels valid: 0..6 then wrap to 0.
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rr_ready_%0d", k), 32'(Din_ready), 32'(1 << (k % 7)));
      tick();
      check_beat($sformatf("rr_beat_%0d", k), 8'(8'h10 + (k % 7)),
                 SEL_W'(k % 7));
    end
    check("rr_ptr_after_rr", 32'(dbg_rr_ptr), 32'd1);

    // Sparse round-robin: bring rr_ptr to 3, then channels 2 and 6 alternate.
    Din_valid = 7'b0000100;
    #1;
    check("sp_ready_a", 32'(Din_ready), 32'h04);
    tick();
    check_beat("sp_beat_a", 8'h12, 3'd2);
    check("sp_ptr_a", 32'(dbg_rr_ptr), 32'd3);

    Din_valid = 7'b1000100;
    #1;
    check("sp_ready_b", 32'(Din_ready), 32'h40);
    tick();
    check_beat("sp_beat_b", 8'h16, 3'd6);
    check("sp_ptr_b", 32'(dbg_rr_ptr), 32'd0);
    check("sp_ready_c", 32'(Din_ready), 32'h04);
    tick();
    check_beat("sp_beat_c", 8'h12, 3'd2);
    check("sp_ptr_c", 32'(dbg_rr_ptr), 32'd3);
    check("sp_ready_d", 32'(Din_ready), 32'h40);
    tick();
    check_beat("sp_beat_d", 8'h16, 3'd6);
    check("sp_ptr_d", 32'(dbg_rr_ptr), 32'd0);

    // Backpressure: hold for three cycles while producers change data.
    Dout_ready = 1'b0;
    Din_valid  = '1;
    load_din(8'h20);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_ready_%0d", k), 32'(Din_ready), 32'd0);
      tick();
      check_beat($sformatf("bp_hold_%0d", k), 8'h16, 3'd6);
      check($sformatf("bp_ptr_%0d", k), 32'(dbg_rr_ptr), 32'd0);
    end
    Dout_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(Din_ready), 32'h01);
    tick();
    check_beat("bp_release_beat", 8'h20, 3'd0);
    check("bp_release_ptr", 32'(dbg_rr_ptr), 32'd1);

    // Fixed select on channel 4: rr_ptr must not move.
    mode   = 1'b1;
    select = 3'd4;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("fx_ready_%0d", k), 32'(Din_ready), 32'h10);
      tick();
      check_beat($sformatf("fx_beat_%0d", k), 8'h24, 3'd4);
      check($sformatf("fx_ptr_%0d", k), 32'(dbg_rr_ptr), 32'd1);
    end

    // Out-of-range select grants nothing and the held beat drains.
    select = 3'd7;
    #1;
    check("oor_ready", 32'(Din_ready), 32'd0);
    tick();
    check("oor_valid", 32'(Dout_valid), 32'd0);
    check("oor_state", 32'(dbg_state),  32'd0);
    check("oor_data",  32'(Dout),       32'h24);
    check("oor_ch",    32'(Dout_ch),    32'd4);

    // Mode switch: two fixed beats on channel 5, then round-robin resumes at 1.
    select = 3'd5;
    #1;
    check("ms_ready_fixed", 32'(Din_ready), 32'h20);
    tick();
    check_beat("ms_fixed_0", 8'h25, 3'd5);
    tick();
    check_beat("ms_fixed_1", 8'h25, 3'd5);
    check("ms_ptr_kept", 32'(dbg_rr_ptr), 32'd1);
    mode = 1'b0;
    #1;
    check("ms_ready_rr", 32'(Din_ready), 32'h02);
    tick();
    check_beat("ms_rr_beat", 8'h21, 3'd1);
    check("ms_rr_ptr", 32'(dbg_rr_ptr), 32'd2);

    // Reset mid-stream, asserted between edges while a beat is held.
    Dout_ready = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(Dout_valid), 32'd0);
    check("mid_rst_data",  32'(Dout),       32'd0);
    check("mid_rst_ch",    32'(Dout_ch),    32'd0);
    check("mid_rst_ready", 32'(Din_ready),  32'd0);
    check("mid_rst_ptr",   32'(dbg_rr_ptr), 32'd0);
    tick();
    check("mid_rst_ready_edge", 32'(Din_ready), 32'd0);
    Reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(Din_ready), 32'h01);
    tick();
    check_beat("post_rst_beat", 8'h20, 3'd0);

    // Drain with no producers: Dout_valid falls and the data is kept.
    Din_valid  = '0;
    Dout_ready = 1'b1;
    #1;
    check("idle_ready", 32'(Din_ready), 32'd0);
    tick();
    check("idle_valid", 32'(Dout_valid), 32'd0);
    check("idle_data",  32'(Dout),       32'h20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
